ad_da_scheduler: RTL and testbench
==================================

Name: ad_da_scheduler

Overview:
Schedules the two 12-bit ADC sample streams onto the single 14-bit DAC output of the AD/DA board path. Each channel has a one-entry holding register; a programmable rate divider produces the DAC update tick. At each tick a mode-selected source (ch1, ch2, average, round-robin) is converted to 14 bits and driven to the DAC. Underrun and overrun events are counted for bring-up diagnostics.

Parameters:
DIV, 8, DAC update period in clk cycles; legal range 2..255.
RAMP_STEP, 16, 14-bit increment per tick for the ramp pattern (optional feature only).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
enable  input  1  1 = scheduler runs; 0 = idle, DAC held at midscale
mode  input  2  source select: 00 ch1, 01 ch2, 10 average, 11 round-robin
ad_data_in_1  input  12  ADC1 sample, offset binary
ad_valid_1  input  1  ADC1 sample strobe, one cycle per sample
ad_data_in_2  input  12  ADC2 sample, offset binary
ad_valid_2  input  1  ADC2 sample strobe
ramp_en  input  1  selects test ramp (used only with the optional feature)
da_data_out_1  output  14  DAC code, offset binary
da_update  output  1  one-cycle pulse when da_data_out_1 changes source sample
active_ch  output  2  source of the last update: 01 ch1, 10 ch2, 11 both, 00 none or ramp
underrun_cnt  output  8  saturating count of ticks with no fresh selected sample
overrun_cnt  output  8  saturating count of overwritten unread samples

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: da_data_out_1 = 14'h2000, da_update = 0, active_ch = 00, both counters = 0, holding registers empty, FSM = IDLE, divider = 0, round-robin pointer = ch1.
- FSM states:
  - IDLE: DAC = 14'h2000, divider cleared, holding registers flushed. On enable = 1, go to RUN.
  - RUN: divider counts 0..DIV-1. tick = (count == DIV-1). On tick, go to UPDATE.
  - UPDATE (one cycle): register the output and pulse da_update, then return to RUN.
  - enable = 0 in any state: go to IDLE next cycle. An update already in UPDATE completes in that same cycle.
- Latency: tick in cycle T gives da_data_out_1 and da_update valid in cycle T+1. Update spacing is exactly DIV cycles.
- Holding registers:
  - ad_valid_x loads the sample and sets full_x.
  - A load when full_x is set and the sample has not been consumed: overwrite and increment overrun_cnt.
  - A valid arriving in the same cycle as consumption counts as a new fresh sample, not an overrun.
- Consumption: mode is sampled on tick. The selected channel(s) are consumed and full cleared.
  - 00: out = {d1, 2'b00}.
  - 01: out = {d2, 2'b00}.
  - 10: needs both full. out = (d1 + d2) as 13 bits, then {sum, 1'b0}. No rounding; exact, no overflow.
  - 11: serve the pointer channel if full, else the other channel if full. After a served tick, the pointer moves to the channel not served.
- Underrun: the selected source is not full at tick (mode 10: either channel empty; mode 11: both empty).
  - da_data_out_1 holds its previous value, da_update = 0, active_ch = 00, underrun_cnt += 1.
  - Nothing is consumed in that case.
- Counters saturate at 255 and clear only on rst.
- A mode change takes effect at the next tick. The round-robin pointer resets to ch1 whenever mode changes.

Optional Feature:
Macro AD_DA_RAMP_EN.
- Defined: when ramp_en = 1 at tick, output a 14-bit sawtooth.
  - The ramp register starts at 0 and adds RAMP_STEP per tick, wrapping modulo 2^14.
  - da_update pulses, active_ch = 00, no samples are consumed, and underrun is never counted.
  - The ramp register resets in IDLE.
- Not defined: ramp_en is ignored and no ramp logic is present.

Test Plan:
1. rst held, then released with enable = 0 -> da_data_out_1 = 14'h2000, da_update = 0, counters 0.
2. enable = 1, mode 00, DIV = 8, ad_data_in_1 = 12'hABC strobed before each tick -> da_data_out_1 = 14'h2AF0, da_update pulse every 8 cycles, active_ch = 01.
3. mode 10, d1 = 12'hFFF, d2 = 12'hFFF -> 14'h3FFE. Then d1 = 12'h001, d2 = 12'h000 -> 14'h0002.
4. mode 11, only ch2 strobed with 12'h100, then both strobed -> outputs 14'h0400 (ch2), then ch1, then ch2 alternating; active_ch follows the source.
5. No strobes for 300 ticks in mode 00 -> output held, da_update = 0, underrun_cnt = 255 (saturated). Three ch1 strobes between consecutive ticks -> overrun_cnt += 2.
6. enable dropped mid-run -> IDLE next cycle, output 14'h2000. With AD_DA_RAMP_EN and ramp_en = 1 -> outputs 0, 16, 32, … and wrap 16368 -> 0.

Source files
------------

// File: rtl/ad_da_scheduler.sv
// Schedules two 12-bit ADC sample streams onto one 14-bit DAC at a fixed update rate.
// Optional test sawtooth on the DAC is built only when AD_DA_RAMP_EN is defined.
module ad_da_scheduler #(
    parameter int unsigned DIV       = 8,
    parameter logic [13:0] RAMP_STEP = 14'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [11:0] ad_data_in_1,
    input  logic        ad_valid_1,
    input  logic [11:0] ad_data_in_2,
    input  logic        ad_valid_2,
    input  logic        ramp_en,
    output logic [13:0] da_data_out_1,
    output logic        da_update,
    output logic [1:0]  active_ch,
    output logic [7:0]  underrun_cnt,
    output logic [7:0]  overrun_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_UPDATE = 2'b10
    } state_t;

    localparam logic [7:0]  DIV_LAST = 8'(DIV - 1);
    localparam logic [13:0] MIDSCALE = 14'h2000;

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    state_t      state_r;
    logic [7:0]  count_r;
    logic [11:0] d1_r;
    logic [11:0] d2_r;
    logic        full1_r;
    logic        full2_r;
    logic        rr_ptr_r;
    logic [1:0]  mode_prev_r;

    logic        tick_s;
    logic        ramp_sel_s;
    logic        rr_ptr_eff_s;
    logic        fresh_s;
    logic [13:0] code_s;
    logic [1:0]  act_s;
    logic        take1_s;
    logic        take2_s;
    logic        rr_next_s;
    logic        serve1_s;
    logic        serve2_s;
    logic        consume1_s;
    logic        consume2_s;
    logic [1:0]  ov_inc_s;
    logic [12:0] sum_s;

`ifdef AD_DA_RAMP_EN
    logic [13:0] ramp_r;
    assign ramp_sel_s = ramp_en;
`else
    logic [14:0] unused_ramp_s;
    assign unused_ramp_s = {ramp_en, RAMP_STEP};
    assign ramp_sel_s    = 1'b0;
`endif

    // The divider keeps running through UPDATE so that updates are exactly DIV cycles apart.
    assign tick_s       = (state_r == ST_RUN) && enable && (count_r == DIV_LAST);
    // A mode change in the tick cycle must already see the pointer back at ch1.
    assign rr_ptr_eff_s = (mode != mode_prev_r) ? 1'b0 : rr_ptr_r;
    assign sum_s        = {1'b0, d1_r} + {1'b0, d2_r};
    assign serve1_s     = rr_ptr_eff_s ? (full1_r && !full2_r) : full1_r;
    assign serve2_s     = rr_ptr_eff_s ? full2_r : (full2_r && !full1_r);
    assign consume1_s   = tick_s && !ramp_sel_s && take1_s;
    assign consume2_s   = tick_s && !ramp_sel_s && take2_s;
    assign ov_inc_s     = {1'b0, ad_valid_1 && full1_r && !consume1_s}
                        + {1'b0, ad_valid_2 && full2_r && !consume2_s};

    // Source selection for the next tick: code, channel tag and which holding registers drain.
    always_comb begin
        fresh_s   = 1'b0;
        code_s    = da_data_out_1;
        act_s     = 2'b00;
        take1_s   = 1'b0;
        take2_s   = 1'b0;
        rr_next_s = rr_ptr_eff_s;
        case (mode)
            2'b00: begin
                if (full1_r) begin
                    fresh_s = 1'b1;
                    code_s  = {d1_r, 2'b00};
                    act_s   = 2'b01;
                    take1_s = 1'b1;
                end else begin
                    fresh_s = 1'b0;
                end
            end
            2'b01: begin
                if (full2_r) begin
                    fresh_s = 1'b1;
                    code_s  = {d2_r, 2'b00};
                    act_s   = 2'b10;
                    take2_s = 1'b1;
                end else begin
                    fresh_s = 1'b0;
                end
            end
            2'b10: begin
                if (full1_r && full2_r) begin
                    fresh_s = 1'b1;
                    code_s  = {sum_s, 1'b0};
                    act_s   = 2'b11;
                    take1_s = 1'b1;
                    take2_s = 1'b1;
                end else begin
                    fresh_s = 1'b0;
                end
            end
            2'b11: begin
                if (serve1_s) begin
                    fresh_s   = 1'b1;
                    code_s    = {d1_r, 2'b00};
                    act_s     = 2'b01;
                    take1_s   = 1'b1;
                    rr_next_s = 1'b1;
                end else if (serve2_s) begin
                    fresh_s   = 1'b1;
                    code_s    = {d2_r, 2'b00};
                    act_s     = 2'b10;
                    take2_s   = 1'b1;
                    rr_next_s = 1'b0;
                end else begin
                    fresh_s = 1'b0;
                end
            end
            default: begin
                fresh_s = 1'b0;
            end
        endcase
    end

    // Scheduler FSM, holding registers, diagnostic counters and registered DAC outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            count_r       <= 8'd0;
            d1_r          <= 12'd0;
            d2_r          <= 12'd0;
            full1_r       <= 1'b0;
            full2_r       <= 1'b0;
            rr_ptr_r      <= 1'b0;
            mode_prev_r   <= 2'b00;
            da_data_out_1 <= MIDSCALE;
            da_update     <= 1'b0;
            active_ch     <= 2'b00;
            underrun_cnt  <= 8'd0;
            overrun_cnt   <= 8'd0;
`ifdef AD_DA_RAMP_EN
            ramp_r        <= 14'd0;
`endif
        end else begin
            mode_prev_r <= mode;
            if (tick_s && !ramp_sel_s && fresh_s && (mode == 2'b11)) begin
                rr_ptr_r <= rr_next_s;
            end else if (mode != mode_prev_r) begin
                rr_ptr_r <= 1'b0;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end

            case (state_r)
                ST_RUN, ST_UPDATE: begin
                    if (!enable) begin
                        state_r       <= ST_IDLE;
                        count_r       <= 8'd0;
                        full1_r       <= 1'b0;
                        full2_r       <= 1'b0;
                        da_data_out_1 <= MIDSCALE;
                        da_update     <= 1'b0;
                        active_ch     <= 2'b00;
                    end else begin
                        state_r     <= tick_s ? ST_UPDATE : ST_RUN;
                        count_r     <= (count_r == DIV_LAST) ? 8'd0 : count_r + 8'd1;
                        overrun_cnt <= sat_add(overrun_cnt, ov_inc_s);
                        if (ad_valid_1) begin
                            d1_r    <= ad_data_in_1;
                            full1_r <= 1'b1;
                        end else begin
                            full1_r <= full1_r && !consume1_s;
                        end
                        if (ad_valid_2) begin
                            d2_r    <= ad_data_in_2;
                            full2_r <= 1'b1;
                        end else begin
                            full2_r <= full2_r && !consume2_s;
                        end
                        if (!tick_s) begin
                            da_update <= 1'b0;
                        end else if (ramp_sel_s) begin
`ifdef AD_DA_RAMP_EN
                            da_data_out_1 <= ramp_r;
                            ramp_r        <= ramp_r + RAMP_STEP;
`endif
                            da_update     <= 1'b1;
                            active_ch     <= 2'b00;
                        end else if (fresh_s) begin
                            da_data_out_1 <= code_s;
                            da_update     <= 1'b1;
                            active_ch     <= act_s;
                        end else begin
                            da_update     <= 1'b0;
                            active_ch     <= 2'b00;
                            underrun_cnt  <= sat_add(underrun_cnt, 2'd1);
                        end
                    end
                end
                default: begin
                    state_r       <= enable ? ST_RUN : ST_IDLE;
                    count_r       <= 8'd0;
                    full1_r       <= 1'b0;
                    full2_r       <= 1'b0;
                    da_data_out_1 <= MIDSCALE;
                    da_update     <= 1'b0;
                    active_ch     <= 2'b00;
`ifdef AD_DA_RAMP_EN
                    ramp_r        <= 14'd0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad_da_scheduler.sv
// Directed scoreboard bench for ad_da_scheduler (DIV = 8); ramp steps run only with AD_DA_RAMP_EN.
module tb_ad_da_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [11:0] ad_data_in_1 = 12'd0;
    logic        ad_valid_1 = 1'b0;
    logic [11:0] ad_data_in_2 = 12'd0;
    logic        ad_valid_2 = 1'b0;
    logic        ramp_en = 1'b0;
    logic [13:0] da_data_out_1;
    logic        da_update;
    logic [1:0]  active_ch;
    logic [7:0]  underrun_cnt;
    logic [7:0]  overrun_cnt;

    typedef struct packed {
        logic [13:0] data;
        logic [1:0]  ch;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_upd = 0;
    bit   have_last = 1'b0;

    ad_da_scheduler #(.DIV(8), .RAMP_STEP(14'd16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .ad_data_in_1(ad_data_in_1), .ad_valid_1(ad_valid_1),
        .ad_data_in_2(ad_data_in_2), .ad_valid_2(ad_valid_2),
        .ramp_en(ramp_en), .da_data_out_1(da_data_out_1), .da_update(da_update),
        .active_ch(active_ch), .underrun_cnt(underrun_cnt), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [13:0] data, input logic [1:0] ch);
        exp_t e;
        e.data = data;
        e.ch   = ch;
        exp_q.push_back(e);
    endtask

    task automatic strobe(input bit v1, input logic [11:0] d1, input bit v2, input logic [11:0] d2);
        ad_data_in_1 = d1;
        ad_valid_1   = v1;
        ad_data_in_2 = d2;
        ad_valid_2   = v2;
        step(1);
        ad_valid_1 = 1'b0;
        ad_valid_2 = 1'b0;
    endtask

    task automatic wait_update(input string tag);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (da_update === 1'b1) seen = 1'b1;
            else n++;
        end
        check({tag, "_update_seen"}, 32'(seen), 32'd1);
        step(1);
    endtask

    function automatic logic [13:0] avg_code(input int d1, input int d2);
        return 14'(2 * (d1 + d2));
    endfunction

    // Scoreboard: every DAC update pops one expectation; updates must land on the 8-cycle grid.
    always @(negedge clk) begin
        exp_t e;
        if (!enable) have_last = 1'b0;
        if (da_update === 1'b1) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dac_data", 32'(da_data_out_1), 32'(e.data));
                check("active_ch", 32'(active_ch), 32'(e.ch));
            end
            if (have_last) check("update_spacing", 32'((cyc - last_upd) % 8), 32'd0);
            last_upd  = cyc;
            have_last = 1'b1;
        end
    end

    initial begin
        // Reset and idle state.
        step(3);
        rst = 1'b0;
        step(2);
        check("rst_dac", 32'(da_data_out_1), 32'h2000);
        check("rst_update", 32'(da_update), 32'd0);
        check("rst_active", 32'(active_ch), 32'd0);
        check("rst_underrun", 32'(underrun_cnt), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);

        // Mode 00: ch1 samples, one per update period.
        enable = 1'b1;
        step(1);
        for (int k = 0; k < 4; k++) begin
            strobe(1'b1, 12'hABC, 1'b0, 12'h000);
            push(14'h2AF0, 2'b01);
            wait_update("m00");
        end
        check("m00_pulse_width", 32'(da_update), 32'd0);

        // Mode 10: exact average, doubled into 14 bits.
        mode = 2'b10;
        strobe(1'b1, 12'hFFF, 1'b1, 12'hFFF);
        push(avg_code(32'hFFF, 32'hFFF), 2'b11);
        wait_update("avg_max");
        strobe(1'b1, 12'h001, 1'b1, 12'h000);
        push(avg_code(1, 0), 2'b11);
        wait_update("avg_min");

        // Mode 11: only ch2 ready, then both ready twice -> ch1/ch2 alternation.
        mode = 2'b11;
        strobe(1'b0, 12'h000, 1'b1, 12'h100);
        push(14'h0400, 2'b10);
        wait_update("rr_ch2_only");
        strobe(1'b1, 12'h123, 1'b1, 12'h456);
        push(14'h048C, 2'b01);
        push(14'h1158, 2'b10);
        wait_update("rr_a1");
        wait_update("rr_a2");
        strobe(1'b1, 12'h7FF, 1'b1, 12'h001);
        push(14'h1FFC, 2'b01);
        push(14'h0004, 2'b10);
        wait_update("rr_b1");
        wait_update("rr_b2");
        check("rr_overrun", 32'(overrun_cnt), 32'd0);
        check("rr_underrun", 32'(underrun_cnt), 32'd0);

        // Starvation in mode 00: held output, counted underruns, saturation.
        mode = 2'b00;
        step(24);
        check("under_3", 32'(underrun_cnt), 32'd3);
        check("under_hold_dac", 32'(da_data_out_1), 32'h0004);
        check("under_active", 32'(active_ch), 32'd0);
        step(2400);
        check("under_sat", 32'(underrun_cnt), 32'd255);
        check("under_sat_dac", 32'(da_data_out_1), 32'h0004);

        // Three ch1 strobes inside one period: two overruns, newest sample wins.
        strobe(1'b1, 12'h111, 1'b0, 12'h000);
        strobe(1'b1, 12'h222, 1'b0, 12'h000);
        strobe(1'b1, 12'h333, 1'b0, 12'h000);
        push(14'h0CCC, 2'b01);
        wait_update("overrun_out");
        check("overrun_2", 32'(overrun_cnt), 32'd2);
        check("overrun_under", 32'(underrun_cnt), 32'd255);

        // Disable mid-run: midscale next cycle, counters kept, holding registers flushed.
        step(3);
        enable = 1'b0;
        step(1);
        check("idle_dac", 32'(da_data_out_1), 32'h2000);
        check("idle_update", 32'(da_update), 32'd0);
        check("idle_active", 32'(active_ch), 32'd0);
        strobe(1'b1, 12'h555, 1'b0, 12'h000);
        step(5);
        check("idle_dac_hold", 32'(da_data_out_1), 32'h2000);
        check("idle_overrun", 32'(overrun_cnt), 32'd2);
        enable = 1'b1;
        step(12);
        check("flush_dac", 32'(da_data_out_1), 32'h2000);

`ifdef AD_DA_RAMP_EN
        // Sawtooth from 0 in steps of 16 through the 14-bit wrap.
        enable = 1'b0;
        step(2);
        ramp_en = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 1026; i++) push(14'(i * 16), 2'b00);
        for (int i = 0; i < 1026; i++) wait_update("ramp");
        check("ramp_underrun", 32'(underrun_cnt), 32'd255);
        enable  = 1'b0;
        ramp_en = 1'b0;
        step(2);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
